buyruk_hizalayici: RTL
======================

# buyruk_hizalayici

Parametrised fetch-stage-2 realigner between the L1 instruction cache response port and the decode stage. It accepts fetch blocks of `OBEK_BIT` bits and stores them as 16-bit parcels in a halfword queue. From that queue it produces one RV32IC instruction per handshake: 16-bit compressed or 32-bit, including 32-bit instructions that straddle blocks. It tracks outstanding cache requests so that responses belonging to a flushed stream are drained and dropped, and it gives decode a valid/ready handshake instead of a stall line.

## Interface
- `PS_BIT`, 32, program-counter width.
- `OBEK_BIT`, 32, fetch block width; 32 or 64.
- `KUYRUK_DERINLIK`, 8, halfword queue depth; power of two, at least `2*OBEK_BIT/16`.
- `ISTEK_SAYAC_BIT`, 4, width of the outstanding-request counters.

- `clk_i` in 1: single clock.
- `rstn_i` in 1: reset; asynchronous, active-low.
- `g1_istek_yapildi_i` in 1: fetch stage 1 issued one cache request this cycle.
- `g1_istek_izin_o` out 1: fetch stage 1 may issue a request this cycle.
- `l1b_buyruk_i` in `OBEK_BIT`: cache response data.
- `l1b_ps_i` in `PS_BIT`: PC of the first useful byte in the block; must be halfword-aligned.
- `l1b_gecerli_i` in 1: response valid.
- `l1b_hazir_o` out 1: response accepted when high together with `l1b_gecerli_i`.
- `coz_buyruk_o` out 32: instruction; compressed instructions are zero-extended.
- `coz_ps_o` out `PS_BIT`: PC of the instruction.
- `coz_rvc_o` out 1: instruction is 16-bit.
- `coz_gecerli_o` out 1: instruction valid.
- `coz_hazir_i` in 1: decode accepts the instruction.
- `bosalt_i` in 1: flush (mispredict, redirect or exception).

## Operation
- Halfword queue: `KUYRUK_DERINLIK` entries of 16 bits. `sayi_r` holds occupancy, plus head/tail pointers that wrap modulo the depth, and `bas_ps_r` holds the PC of the head parcel.
- Block acceptance:
  - `ofs = l1b_ps_i[log2(OBEK_BIT/8)-1:1]` parcels of the block are skipped; `OBEK_BIT/16 - ofs` parcels are pushed, lowest address first.
  - If the queue was empty, `bas_ps_r <= l1b_ps_i`.
  - Upstream guarantees that the blocks between flushes are sequential. The bench asserts this.
- Space check: `l1b_hazir_o = (KUYRUK_DERINLIK - sayi_r >= OBEK_BIT/16)` in state NORMAL. It uses registered occupancy only, with no credit taken for a pop in the same cycle.
- Instruction formation, from the head parcel `h0` and the next parcel `h1`:
  - If `h0[1:0] != 2'b11`, the instruction is RVC: `coz_buyruk_o = {16'b0,h0}`, `coz_rvc_o = 1`. It needs 1 parcel.
  - Otherwise the instruction is `{h1,h0}`. It needs 2 parcels. With only 1 parcel present, `coz_gecerli_o = 0` until the next block arrives.
- `coz_gecerli_o = (sayi_r >= needed) && !bosalt_i`, in state NORMAL only.
- Pop on `coz_gecerli_o && coz_hazir_i`: advance by 1 or 2 parcels, and `bas_ps_r += 2` or `4`, modulo `2^PS_BIT`.
- Request accounting:
  - `bekleyen_r` counts issued-but-unanswered requests: +1 on `g1_istek_yapildi_i`, −1 on every response handshake.
  - `g1_istek_izin_o = bekleyen_r != 2^ISTEK_SAYAC_BIT-1`.
- States:
  - NORMAL: `atilacak_r == 0`.
  - ATIS: `atilacak_r != 0`. In ATIS, `l1b_hazir_o = 1`, every response is dropped with `atilacak_r -= 1`, and `coz_gecerli_o = 0`. Leave ATIS when `atilacak_r` reaches 0.
- Flush (`bosalt_i`):
  - Queue cleared (`sayi_r <= 0`).
  - `l1b_hazir_o = 1`, and any response in this cycle is dropped.
  - `atilacak_r <= bekleyen_r - l1b_gecerli_i`.
  - A request issued in the flush cycle belongs to the new stream and counts only in `bekleyen_r`.
  - A flush during ATIS recomputes `atilacak_r` the same way.
  - Flush has priority over push and pop.
- Reset (asynchronous):
  - All state is cleared: queue contents and pointers 0, `sayi_r`, `bekleyen_r` and `atilacak_r` 0, `bas_ps_r` 0, state NORMAL.
  - `coz_buyruk_o`, `coz_ps_o`, `coz_rvc_o` and `coz_gecerli_o` read 0.
  - While `rstn_i` is low, `l1b_hazir_o = 0` and `g1_istek_izin_o = 0`.

## Timing
- Outputs are combinational from registered state. `l1b_hazir_o` and `coz_gecerli_o` additionally depend combinationally on `bosalt_i`.
- A block accepted at edge N makes its first instruction visible to decode in cycle N+1.
- Throughput: one instruction per cycle while the queue holds enough parcels.
- A straddling 32-bit instruction becomes valid the cycle after its second block is accepted.
- Push and pop in the same cycle are both honoured. `sayi_r` is updated by (pushed − popped).

## Structure
- Constants `HIGH`/`LOW` and `BUYRUK_BIT` come from `sabitler.vh`.
- Add `RVC_MASKE` (2'b11) and the state encodings `HIZ_NORMAL`/`HIZ_ATIS` to `sabitler.vh`.
- Sub-module `yarim_kuyruk`: a parametrised halfword FIFO with multi-parcel push (up to `OBEK_BIT/16`) and 1–2 parcel pop, exposing `sayi`, `h0` and `h1`.
- Request accounting and the state machine stay in `buyruk_hizalayici`.

## Test plan
- 32-bit blocks `0x00A00093` at PC `0x0`, then `0x00108113` at `0x4`, `coz_hazir_i = 1` → two 32-bit instructions at PCs `0x0` and `0x4`, `coz_rvc_o = 0`, first valid the cycle after the first accept.
- Block `0x4501_0505` at PC `0x100` → RVC `0x0505` at `0x100`, then RVC `0x4501` at `0x102`.
- Block at `0x202` with upper parcel `0x0093` → nothing valid; next block `0x1234_00A0` at `0x204` → `0x00A00093` at `0x202`, then `0x1234` treated as RVC at `0x206`.
- Three requests issued with no responses, then `bosalt_i` with no response in that cycle → `atilacak_r = 3`; the next three responses are dropped with `l1b_hazir_o = 1`; the fourth is decoded.
- Flush in the same cycle as a response and a new request, with `bekleyen_r = 2` → that response is dropped, `atilacak_r = 1`, `bekleyen_r = 2`.
- `OBEK_BIT = 64`, `coz_hazir_i = 0` → acceptance stops when free parcels < 4; pulsing `rstn_i` low mid-stream clears `coz_gecerli_o` immediately.

Source files
------------

// File: rtl/buyruk_hizalayici_pkg.sv
// rtl/buyruk_hizalayici_pkg.sv - shared constants, state encoding and parcel helper for the fetch realigner
//
// Purpose : common definitions imported by buyruk_hizalayici and yarim_kuyruk.
// Contents: HIGH/LOW levels, BUYRUK_BIT instruction width, PARSEL_BIT parcel width,
//           RVC_MASKE low-bit pattern of a 32-bit instruction, realigner state enum,
//           rvc_mi() compressed-parcel test.
package buyruk_hizalayici_pkg;

  localparam logic       HIGH       = 1'b1;
  localparam logic       LOW        = 1'b0;
  localparam int         BUYRUK_BIT = 32;
  localparam int         PARSEL_BIT = 16;
  localparam logic [1:0] RVC_MASKE  = 2'b11;

  typedef enum logic {
    HIZ_NORMAL = 1'b0,
    HIZ_ATIS   = 1'b1
  } hiz_durum_e;

  // A parcel starts a compressed instruction unless its two low bits are both set.
  function automatic logic rvc_mi(input logic [PARSEL_BIT-1:0] parsel);
    return (parsel[1:0] & RVC_MASKE) != RVC_MASKE;
  endfunction

endpackage

// File: rtl/buyruk_hizalayici_yarim_kuyruk.sv
// rtl/buyruk_hizalayici_yarim_kuyruk.sv - halfword FIFO with multi-parcel push and 1-2 parcel pop
//
// Purpose : stores 16-bit parcels of fetch blocks; pushes the tail part of a block
//           starting at parcel it_ofs_i, pops one or two parcels from the head.
// Ports   : clk_i, rstn_i      clock, asynchronous active-low reset
//           temizle_i          drop all contents (has priority over push/pop)
//           it_i, it_veri_i,   push the block, skipping it_ofs_i low parcels
//           it_ofs_i
//           cek_i, cek_iki_i   pop one parcel, or two when cek_iki_i
//           sayi_o             occupancy in parcels
//           h0_o, h1_o         head parcel and the one after it
module yarim_kuyruk
  import buyruk_hizalayici_pkg::*;
#(
  parameter  int OBEK_BIT = 32,
  parameter  int DERINLIK = 8,
  localparam int P        = OBEK_BIT / PARSEL_BIT,
  localparam int OFS_BIT  = $clog2(P),
  localparam int ADR_BIT  = $clog2(DERINLIK),
  localparam int SAYI_BIT = $clog2(DERINLIK + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  temizle_i,
  input  logic                  it_i,
  input  logic [OBEK_BIT-1:0]   it_veri_i,
  input  logic [OFS_BIT-1:0]    it_ofs_i,
  input  logic                  cek_i,
  input  logic                  cek_iki_i,
  output logic [SAYI_BIT-1:0]   sayi_o,
  output logic [PARSEL_BIT-1:0] h0_o,
  output logic [PARSEL_BIT-1:0] h1_o
);

  logic [PARSEL_BIT-1:0] bellek_q [DERINLIK];
  logic [ADR_BIT-1:0]    bas_q;
  logic [ADR_BIT-1:0]    kuyruk_q;
  logic [SAYI_BIT-1:0]   sayi_q;

  logic [PARSEL_BIT-1:0] kaydirilmis [P];
  logic [SAYI_BIT-1:0]   it_adet;
  logic [SAYI_BIT-1:0]   cek_adet;

  // Rotate the block so that the first useful parcel lands in slot 0; only the
  // first it_adet slots are ever written, so the wrapped-around ones are unused.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      logic [OFS_BIT-1:0] kaynak;
      kaynak         = it_ofs_i + OFS_BIT'(i);
      kaydirilmis[i] = it_veri_i[PARSEL_BIT*kaynak +: PARSEL_BIT];
    end
    it_adet  = it_i ? (SAYI_BIT'(P) - SAYI_BIT'(it_ofs_i)) : '0;
    cek_adet = cek_i ? (cek_iki_i ? SAYI_BIT'(2) : SAYI_BIT'(1)) : '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DERINLIK; i++) bellek_q[i] <= '0;
      bas_q    <= '0;
      kuyruk_q <= '0;
      sayi_q   <= '0;
    end else if (temizle_i) begin
      bas_q    <= '0;
      kuyruk_q <= '0;
      sayi_q   <= '0;
    end else begin
      if (it_i) begin
        for (int i = 0; i < P; i++) begin
          if (SAYI_BIT'(i) < it_adet) bellek_q[kuyruk_q + ADR_BIT'(i)] <= kaydirilmis[i];
        end
        kuyruk_q <= kuyruk_q + ADR_BIT'(it_adet);
      end
      bas_q  <= bas_q + ADR_BIT'(cek_adet);
      sayi_q <= sayi_q + it_adet - cek_adet;
    end
  end

  assign sayi_o = sayi_q;
  assign h0_o   = bellek_q[bas_q];
  assign h1_o   = bellek_q[bas_q + ADR_BIT'(1)];

endmodule

// File: rtl/buyruk_hizalayici.sv
// rtl/buyruk_hizalayici.sv - fetch-stage-2 realigner from cache blocks to RV32IC instructions
//
// Purpose : accepts fetch blocks into a halfword queue, hands decode one 16- or 32-bit
//           instruction per handshake, and drops cache responses of flushed streams.
// Ports   : clk_i, rstn_i            clock, asynchronous active-low reset
//           g1_istek_yapildi_i       stage 1 issued a cache request
//           g1_istek_izin_o          stage 1 may issue a request
//           l1b_buyruk_i/ps_i/       cache response block, PC of first useful byte,
//           gecerli_i, l1b_hazir_o   valid/ready
//           coz_buyruk_o/ps_o/rvc_o  instruction (RVC zero-extended), its PC, 16-bit flag
//           coz_gecerli_o/hazir_i    decode valid/ready
//           bosalt_i                 flush
module buyruk_hizalayici
  import buyruk_hizalayici_pkg::*;
#(
  parameter int PS_BIT          = 32,
  parameter int OBEK_BIT        = 32,
  parameter int KUYRUK_DERINLIK = 8,
  parameter int ISTEK_SAYAC_BIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  g1_istek_yapildi_i,
  output logic                  g1_istek_izin_o,
  input  logic [OBEK_BIT-1:0]   l1b_buyruk_i,
  input  logic [PS_BIT-1:0]     l1b_ps_i,
  input  logic                  l1b_gecerli_i,
  output logic                  l1b_hazir_o,
  output logic [BUYRUK_BIT-1:0] coz_buyruk_o,
  output logic [PS_BIT-1:0]     coz_ps_o,
  output logic                  coz_rvc_o,
  output logic                  coz_gecerli_o,
  input  logic                  coz_hazir_i,
  input  logic                  bosalt_i
);

  localparam int P        = OBEK_BIT / PARSEL_BIT;
  localparam int OFS_BIT  = $clog2(P);
  localparam int BAYT_ADR = $clog2(OBEK_BIT / 8);
  localparam int SAYI_BIT = $clog2(KUYRUK_DERINLIK + 1);

  hiz_durum_e                 durum_q, durum_d;
  logic [ISTEK_SAYAC_BIT-1:0] bekleyen_q, bekleyen_d;
  logic [ISTEK_SAYAC_BIT-1:0] atilacak_q, atilacak_d;
  logic [PS_BIT-1:0]          bas_ps_q, bas_ps_d;

  logic [SAYI_BIT-1:0]   sayi;
  logic [PARSEL_BIT-1:0] h0;
  logic [PARSEL_BIT-1:0] h1;
  logic                  rvc;
  logic [SAYI_BIT-1:0]   gerekli;
  logic                  cevap_el;
  logic                  it;
  logic                  cek;

  yarim_kuyruk #(
    .OBEK_BIT (OBEK_BIT),
    .DERINLIK (KUYRUK_DERINLIK)
  ) u_kuyruk (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .temizle_i (bosalt_i),
    .it_i      (it),
    .it_veri_i (l1b_buyruk_i),
    .it_ofs_i  (l1b_ps_i[BAYT_ADR-1:1]),
    .cek_i     (cek),
    .cek_iki_i (!rvc),
    .sayi_o    (sayi),
    .h0_o      (h0),
    .h1_o      (h1)
  );

  assign rvc     = rvc_mi(h0);
  assign gerekli = rvc ? SAYI_BIT'(1) : SAYI_BIT'(2);

  // Space is judged on registered occupancy only; a pop in the same cycle earns no credit.
  // While draining or flushing every response is taken so the cache port never backs up.
  assign l1b_hazir_o = rstn_i && (bosalt_i || (durum_q == HIZ_ATIS) ||
                       ((SAYI_BIT'(KUYRUK_DERINLIK) - sayi) >= SAYI_BIT'(P)));
  assign coz_gecerli_o = (durum_q == HIZ_NORMAL) && !bosalt_i && (sayi >= gerekli);
  assign g1_istek_izin_o = rstn_i && (bekleyen_q != '1);

  assign cevap_el = l1b_gecerli_i && l1b_hazir_o;
  assign it       = cevap_el && !bosalt_i && (durum_q == HIZ_NORMAL);
  assign cek      = coz_gecerli_o && coz_hazir_i;

  // An empty queue reads stale or reset contents; keep the RVC flag low there.
  assign coz_buyruk_o = rvc ? {{(BUYRUK_BIT-PARSEL_BIT){1'b0}}, h0} : {h1, h0};
  assign coz_rvc_o    = rvc && (sayi != '0);
  assign coz_ps_o     = bas_ps_q;

  always_comb begin
    durum_d    = durum_q;
    atilacak_d = atilacak_q;
    bekleyen_d = bekleyen_q + ISTEK_SAYAC_BIT'(g1_istek_yapildi_i) - ISTEK_SAYAC_BIT'(cevap_el);
    bas_ps_d   = bas_ps_q;

    // A request issued in the flush cycle belongs to the new stream, so only
    // requests already outstanding (minus a response arriving now) are to be dropped.
    if (bosalt_i == HIGH) begin
      atilacak_d = bekleyen_q - ISTEK_SAYAC_BIT'(l1b_gecerli_i);
      durum_d    = (atilacak_d != '0) ? HIZ_ATIS : HIZ_NORMAL;
    end else if ((durum_q == HIZ_ATIS) && (cevap_el == HIGH)) begin
      atilacak_d = atilacak_q - ISTEK_SAYAC_BIT'(1);
      if (atilacak_d == '0) durum_d = HIZ_NORMAL;
    end

    // Blocks are sequential within a stream, so the head PC only needs loading
    // when a block lands in an empty queue.
    if (it && (sayi == '0)) begin
      bas_ps_d = l1b_ps_i;
    end else if (cek) begin
      bas_ps_d = bas_ps_q + (rvc ? PS_BIT'(2) : PS_BIT'(4));
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q    <= HIZ_NORMAL;
      bekleyen_q <= '0;
      atilacak_q <= '0;
      bas_ps_q   <= '0;
    end else begin
      durum_q    <= durum_d;
      bekleyen_q <= bekleyen_d;
      atilacak_q <= atilacak_d;
      bas_ps_q   <= bas_ps_d;
    end
  end

endmodule
